// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fetch_entry_t : one buffered fetch {inst, pc, trap}
//   fetch_state_e : RUN (fetching) / TRAP (holding a misaligned-redirect marker)
//   INST_NOP      : canonical bubble (addi x0,x0,0) for downstream stages
package fetch_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        trap;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer with wrap-around pointers.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   pop        : retire the head entry
//   flush      : empty the buffer; a same-cycle push lands as the only entry
//   count      : occupancy, $clog2(DEPTH)+1 bits
//   head       : entry at the head (undefined while count==0)
import fetch_pkg::*;

module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   wr_idx;

  // A push that coincides with a flush restarts the buffer at slot 0.
  assign wr_idx = flush ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end feeding decode.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   o_imem_raddr/ren   : fetch request (word aligned), accepted when i_imem_ready
//   i_imem_valid/rdata : in-order response stream
//   o_inst_valid/inst/inst_pc/inst_trap : buffered head to decode
//   i_inst_ready       : decode consumes the head
//   i_redirect/_pc     : flush and refetch from a new PC
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  output logic        o_imem_ren,
  input  logic        i_imem_ready,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_trap,
  input  logic        i_inst_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic          live;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_data;
  logic [CW:0]   occupancy;
  logic          credit;
  logic          accept;
  logic          resp_keep;
  logic          misaligned;
  logic          push;
  logic          pop;

  // Requests in flight plus buffered words bound the buffer, so responses are never refused.
  assign occupancy  = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit     = occupancy < (CW + 1)'(FIFO_DEPTH);
  // live holds off issue for the first cycle after reset.
  assign o_imem_ren = live && (state == RUN) && !i_redirect && credit;
  assign o_imem_raddr = fetch_pc & ~32'h3;
  assign accept     = o_imem_ren && i_imem_ready;

  assign misaligned = !is_aligned(i_redirect_pc);
  assign resp_keep  = i_imem_valid && !i_redirect && (drop == '0);
  assign push       = resp_keep || (i_redirect && misaligned);
  assign pop        = o_inst_valid && i_inst_ready && !i_redirect;

  always_comb begin
    push_data = '{inst: i_imem_rdata, pc: resp_pc, trap: 1'b0};
    if (i_redirect) begin
      push_data = '{inst: '0, pc: i_redirect_pc, trap: 1'b1};
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (i_redirect),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= RUN;
      fetch_pc <= RESET_ADDR;
      resp_pc  <= RESET_ADDR;
      inflight <= '0;
      drop     <= '0;
      live     <= 1'b0;
    end else begin
      live     <= 1'b1;
      inflight <= inflight + CW'(accept) - CW'(i_imem_valid);
      if (i_redirect) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        drop     <= inflight - CW'(i_imem_valid);
        fetch_pc <= i_redirect_pc;
        resp_pc  <= i_redirect_pc;
        state    <= misaligned ? TRAP : RUN;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (i_imem_valid) begin
          if (drop != '0) drop    <= drop - CW'(1);
          else            resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  assign o_inst_valid = fifo_count != '0;
  assign o_inst       = o_inst_valid ? fifo_head.inst : '0;
  assign o_inst_pc    = o_inst_valid ? fifo_head.pc   : '0;
  assign o_inst_trap  = o_inst_valid && fifo_head.trap;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based model of the request stream,
// memory and fetch buffer is checked against the DUT every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_raddr;
  logic        imem_ren;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_trap;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_ADDR(RST_ADDR),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_raddr (imem_raddr),
    .o_imem_ren   (imem_ren),
    .i_imem_ready (imem_ready),
    .i_imem_valid (imem_valid),
    .i_imem_rdata (imem_rdata),
    .o_inst_valid (inst_valid),
    .o_inst       (inst),
    .o_inst_pc    (inst_pc),
    .o_inst_trap  (inst_trap),
    .i_inst_ready (inst_ready),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] epoch;
    logic [31:0] due;
  } req_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        trap;
  } ent_t;

  req_t memq[$];   // accepted requests awaiting a response
  ent_t bufq[$];   // words decode should see, in order

  logic [31:0] m_fetch_pc;
  logic        m_live;
  logic        m_trap;
  logic        m_in_reset;
  logic [31:0] epoch;
  int unsigned cyc;
  int unsigned n_accept;

  int unsigned k_ready, k_lat_min, k_lat_max, k_pop, k_redir, k_rst_pm;
  logic        redir_on_resp;
  logic [31:0] redir_on_resp_pc;
  logic        redir_hit;

  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic set_knobs(input int unsigned rdy, input int unsigned lmin,
                           input int unsigned lmax, input int unsigned pp,
                           input int unsigned rd);
    k_ready = rdy; k_lat_min = lmin; k_lat_max = lmax; k_pop = pp; k_redir = rd;
  endtask

  task automatic run_cycle(input bit f_rst, input bit f_redir, input logic [31:0] f_pc);
    logic  exp_ren, accept, live_push, pop;
    req_t  r;
    @(negedge clk);
    rst        = f_rst || ($urandom_range(0, 999) < k_rst_pm);
    imem_ready = $urandom_range(0, 99) < k_ready;
    inst_ready = $urandom_range(0, 99) < k_pop;
    imem_valid = !rst && (memq.size() != 0) && (memq[0].due <= cyc);
    imem_rdata = imem_valid ? mem_word(memq[0].addr) : $urandom;
    redirect   = 1'b0;
    redirect_pc = $urandom;
    if (!rst) begin
      if (f_redir) begin
        redirect = 1'b1; redirect_pc = f_pc;
      end else if (redir_on_resp && imem_valid && bufq.size() != 0 && inst_ready) begin
        redirect = 1'b1; redirect_pc = redir_on_resp_pc; redir_hit = 1'b1;
      end else if ($urandom_range(0, 99) < k_redir) begin
        redirect = 1'b1;
        redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
        if ($urandom_range(0, 5) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      end
    end
    #1;
    exp_ren = 1'b0;
    if (rst) begin
      if (m_in_reset) begin
        check_eq("rst_ren",   imem_ren,   0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_raddr", imem_raddr, RST_ADDR);
      end
    end else begin
      exp_ren = m_live && !m_trap && !redirect && (memq.size() + bufq.size() < DEPTH);
      check_eq("ren", imem_ren, exp_ren);
      if (exp_ren) check_eq("raddr", imem_raddr, m_fetch_pc);
      check_eq("valid", inst_valid, bufq.size() != 0);
      if (bufq.size() != 0) begin
        check_eq("inst", inst,      bufq[0].inst);
        check_eq("pc",   inst_pc,   bufq[0].pc);
        check_eq("trap", inst_trap, bufq[0].trap);
      end else if (!m_live) begin
        check_eq("post_rst_inst",  inst,       0);
        check_eq("post_rst_pc",    inst_pc,    0);
        check_eq("post_rst_trap",  inst_trap,  0);
        check_eq("post_rst_raddr", imem_raddr, RST_ADDR);
      end
    end
    // Advance the model to match the coming clock edge.
    if (rst) begin
      memq.delete(); bufq.delete();
      m_fetch_pc = RST_ADDR; m_live = 1'b0; m_trap = 1'b0; m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      live_push  = 1'b0;
      r          = '0;
      if (imem_valid) begin
        r = memq.pop_front();
        live_push = !redirect && (r.epoch == epoch);
      end
      pop = (bufq.size() != 0) && inst_ready && !redirect;
      if (pop) void'(bufq.pop_front());
      if (live_push) bufq.push_back('{inst: mem_word(r.addr), pc: r.addr, trap: 1'b0});
      accept = exp_ren && imem_ready;
      if (accept) begin
        memq.push_back('{addr: m_fetch_pc, epoch: epoch,
                         due: cyc + $urandom_range(k_lat_min, k_lat_max)});
        m_fetch_pc += 32'd4;
        n_accept++;
      end
      if (redirect) begin
        bufq.delete();
        epoch++;
        m_fetch_pc = redirect_pc;
        m_trap = redirect_pc[1:0] != 2'b00;
        if (m_trap) bufq.push_back('{inst: 32'h0, pc: redirect_pc, trap: 1'b1});
      end
      m_live = 1'b1;
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m_fetch_pc = RST_ADDR; m_live = 1'b0; m_trap = 1'b0; m_in_reset = 1'b0;
    epoch = '0; cyc = 0; n_accept = 0; n_checks = 0; n_fail = 0;
    redir_on_resp = 1'b0; redir_on_resp_pc = '0; redir_hit = 1'b0;
    k_rst_pm = 0;
    set_knobs(100, 1, 1, 100, 0);

    repeat (3) run_cycle(1, 0, '0);

    // zero-wait memory, decode always ready
    repeat (30) run_cycle(0, 0, '0);

    // decode stalled with 3-cycle memory latency
    repeat (2) run_cycle(1, 0, '0);
    set_knobs(100, 3, 3, 0, 0);
    n_accept = 0;
    repeat (10) run_cycle(0, 0, '0);
    check_eq("stall_accepts", n_accept, DEPTH);
    k_pop = 100;
    repeat (12) run_cycle(0, 0, '0);

    // redirect with requests in flight
    repeat (2) run_cycle(1, 0, '0);
    set_knobs(100, 3, 3, 100, 0);
    repeat (4) run_cycle(0, 0, '0);
    run_cycle(0, 1, 32'h0000_0100);
    repeat (12) run_cycle(0, 0, '0);

    // redirect coinciding with a response and a pop
    set_knobs(100, 1, 2, 100, 0);
    redir_on_resp = 1'b1; redir_on_resp_pc = 32'h0000_0300; redir_hit = 1'b0;
    for (int i = 0; i < 40 && !redir_hit; i++) run_cycle(0, 0, '0);
    redir_on_resp = 1'b0;
    check_eq("redir_resp_hit", redir_hit, 1);
    repeat (8) run_cycle(0, 0, '0);

    // misaligned redirect holds a trap marker, aligned redirect resumes
    k_pop = 0;
    run_cycle(0, 1, 32'h0000_0102);
    repeat (5) run_cycle(0, 0, '0);
    k_pop = 100;
    repeat (5) run_cycle(0, 0, '0);
    run_cycle(0, 1, 32'h0000_0200);
    repeat (12) run_cycle(0, 0, '0);

    // memory back-pressure, then reset mid-stream
    k_ready = 0;
    repeat (5) run_cycle(0, 0, '0);
    k_ready = 100;
    repeat (6) run_cycle(0, 0, '0);
    run_cycle(1, 0, '0);
    repeat (10) run_cycle(0, 0, '0);

    // PC wrap past 2^32
    run_cycle(0, 1, 32'hFFFF_FFF8);
    repeat (12) run_cycle(0, 0, '0);

    // randomized traffic
    k_rst_pm = 2;
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs($urandom_range(30, 100), 1, $urandom_range(1, 5),
                $urandom_range(20, 100), $urandom_range(0, 8));
      repeat (200) run_cycle(0, 0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
